lsu_axi_wr_arb: RTL and testbench

- Shares the single LSU→AXI write interface (lsu_axi_aw*/w*/b*) among NUM_REQ write requesters, e.g. ORAM evict engine, stash flush, DMA.
- Round-robin arbitration per command. The W channel stays locked to the winner until all of its beats have passed.
- Tracks outstanding commands in issue order and merges the awnum per-burst B responses into one response per command, returned to the owning requester.

---
 rtl/lsu_axi_wr_arb_pkg.sv | 46 ++++
 rtl/lsu_axi_wr_arb_ost_fifo.sv | 40 ++++
 rtl/lsu_axi_wr_arb.sv | 229 ++++++++++++++++++++++
 tb/tb_lsu_axi_wr_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_wr_arb_pkg.sv
// Shared types, field widths and helpers for the LSU AXI write arbiter.
package lsu_axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'd0;
  localparam logic [1:0] BRESP_EXOKAY = 2'd1;
  localparam logic [1:0] BRESP_SLVERR = 2'd2;
  localparam logic [1:0] BRESP_DECERR = 2'd3;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned STR_W      = 3;
  localparam int unsigned NUM_W      = 4;
  localparam int unsigned ORAM_W     = 12;
  localparam int unsigned ID_W       = 8;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STRB_W     = 8;
  localparam int unsigned BEAT_CNT_W = 12;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [STR_W-1:0]   str;
    logic [NUM_W-1:0]   num;
    logic [ORAM_W-1:0]  oram;
  } aw_cmd_t;

  // A zero burst count still issues one burst.
  function automatic logic [NUM_W-1:0] num_eff(input logic [NUM_W-1:0] n);
    return (n == '0) ? NUM_W'(1) : n;
  endfunction

  function automatic logic [1:0] bresp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/lsu_axi_wr_arb_ost_fifo.sv
// Outstanding-command FIFO: {requester index, effective burst count} in issue order.
module wr_arb_ost_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign rdata = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (PTR_W+1)'(1);
      if (pop && !empty) rptr <= rptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/lsu_axi_wr_arb.sv
// Arbitrates NUM_REQ write requesters onto one LSU AXI write port and merges per-burst B responses.
// Define WR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module lsu_axi_wr_arb
  import lsu_axi_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_awvld,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_awaddr,
  input  logic [NUM_REQ*LEN_W-1:0]    req_awlen,
  input  logic [NUM_REQ*SIZE_W-1:0]   req_awsize,
  input  logic [NUM_REQ*BURST_W-1:0]  req_awburst,
  input  logic [NUM_REQ*STR_W-1:0]    req_awstr,
  input  logic [NUM_REQ*NUM_W-1:0]    req_awnum,
  input  logic [NUM_REQ*ORAM_W-1:0]   req_oram_addr,
  output logic [NUM_REQ-1:0]          req_awrdy,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
  input  logic [NUM_REQ-1:0]          req_wvld,
  output logic [NUM_REQ-1:0]          req_wrdy,
  output logic [NUM_REQ-1:0]          req_bvld,
  output logic [1:0]                  req_bresp,
  input  logic [NUM_REQ-1:0]          req_brdy,
  output logic [ID_W-1:0]             lsu_axi_awid,
  output logic [ADDR_W-1:0]           lsu_axi_awaddr,
  output logic [LEN_W-1:0]            lsu_axi_awlen,
  output logic [SIZE_W-1:0]           lsu_axi_awsize,
  output logic [BURST_W-1:0]          lsu_axi_awburst,
  output logic [STR_W-1:0]            lsu_axi_awstr,
  output logic [NUM_W-1:0]            lsu_axi_awnum,
  output logic                        lsu_axi_awvld,
  output logic [ORAM_W-1:0]           lsu_axi_oram_addr,
  input  logic                        axi_lsu_awrdy,
  output logic [DATA_W-1:0]           lsu_axi_wdata,
  output logic [STRB_W-1:0]           lsu_axi_wstrb,
  output logic                        lsu_axi_wlast,
  output logic                        lsu_axi_wvld,
  input  logic                        axi_lsu_wrdy,
  input  logic [1:0]                  axi_lsu_bresp,
  input  logic                        axi_lsu_bvld,
  output logic                        lsu_axi_brdy
);

  localparam int unsigned ENT_W = IDX_W + NUM_W;

  wr_state_e               state;
  logic [IDX_W-1:0]        idx;
  aw_cmd_t                 cmd_q;
  logic                    awvld_q;
  logic [BEAT_CNT_W-1:0]   beats_left;
  logic [LEN_W-1:0]        beat_in_burst;
`ifndef WR_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]        rr_ptr;
`endif

  logic                    gnt_vld;
  logic [IDX_W-1:0]        gnt_idx;
  aw_cmd_t                 req_cmd;
  logic [BEAT_CNT_W-1:0]   total_m1;
  logic                    in_data, aw_fire, w_fire, b_fire;

  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [ENT_W-1:0]        fifo_rdata;
  logic [IDX_W-1:0]        head_idx;
  logic [NUM_W-1:0]        head_num;
  logic                    b_last;
  logic [1:0]              acc_next;

  logic [NUM_W-1:0]        resp_cnt;
  logic [1:0]              resp_acc;
  logic                    resp_hold;
  logic [IDX_W-1:0]        bidx;
  logic [1:0]              bresp_q;
  logic                    brdy_en;
  logic                    err_unexp;

  // Pick the first valid requester, scanning from the highest offset down so the lowest wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
`ifdef WR_ARB_FIXED_PRIO_EN
      if (req_awvld[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
`else
      if (req_awvld[(int'(rr_ptr) + i) % int'(NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'((int'(rr_ptr) + i) % int'(NUM_REQ));
      end
`endif
    end
  end

  always_comb begin
    req_cmd.addr  = req_awaddr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    req_cmd.len   = req_awlen[int'(gnt_idx)*LEN_W +: LEN_W];
    req_cmd.size  = req_awsize[int'(gnt_idx)*SIZE_W +: SIZE_W];
    req_cmd.burst = req_awburst[int'(gnt_idx)*BURST_W +: BURST_W];
    req_cmd.str   = req_awstr[int'(gnt_idx)*STR_W +: STR_W];
    req_cmd.num   = req_awnum[int'(gnt_idx)*NUM_W +: NUM_W];
    req_cmd.oram  = req_oram_addr[int'(gnt_idx)*ORAM_W +: ORAM_W];
    total_m1 = BEAT_CNT_W'(num_eff(req_cmd.num)) * (BEAT_CNT_W'(req_cmd.len) + BEAT_CNT_W'(1))
               - BEAT_CNT_W'(1);
  end

  assign in_data = (state == DATA);
  assign aw_fire = awvld_q && axi_lsu_awrdy;
  assign w_fire  = lsu_axi_wvld && axi_lsu_wrdy;

  // Command/data sequencer; payload is captured at grant so a dropped awvld still issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cmd_q         <= '0;
      awvld_q       <= 1'b0;
      beats_left    <= '0;
      beat_in_burst <= '0;
`ifndef WR_ARB_FIXED_PRIO_EN
      rr_ptr        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_vld && !fifo_full) begin
          idx           <= gnt_idx;
          cmd_q         <= req_cmd;
          awvld_q       <= 1'b1;
          beats_left    <= total_m1;
          beat_in_burst <= '0;
          state         <= CMD;
        end
        CMD: if (axi_lsu_awrdy) begin
          awvld_q <= 1'b0;
          state   <= DATA;
        end
        DATA: if (w_fire) begin
          beat_in_burst <= (beat_in_burst == cmd_q.len) ? '0 : beat_in_burst + LEN_W'(1);
          beats_left    <= beats_left - BEAT_CNT_W'(1);
          if (beats_left == '0) begin
            state <= IDLE;
`ifndef WR_ARB_FIXED_PRIO_EN
            rr_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_axi_awvld     = awvld_q;
  assign lsu_axi_awid      = ID_W'(idx);
  assign lsu_axi_awaddr    = cmd_q.addr;
  assign lsu_axi_awlen     = cmd_q.len;
  assign lsu_axi_awsize    = cmd_q.size;
  assign lsu_axi_awburst   = cmd_q.burst;
  assign lsu_axi_awstr     = cmd_q.str;
  assign lsu_axi_awnum     = cmd_q.num;
  assign lsu_axi_oram_addr = cmd_q.oram;
  assign req_awrdy         = aw_fire ? (NUM_REQ'(1) << idx) : '0;

  assign lsu_axi_wvld  = in_data && req_wvld[idx];
  assign lsu_axi_wlast = in_data && (beat_in_burst == cmd_q.len);
  assign lsu_axi_wdata = in_data ? req_wdata[int'(idx)*DATA_W +: DATA_W] : '0;
  assign lsu_axi_wstrb = in_data ? req_wstrb[int'(idx)*STRB_W +: STRB_W] : '0;
  assign req_wrdy      = (in_data && axi_lsu_wrdy) ? (NUM_REQ'(1) << idx) : '0;

  wr_arb_ost_fifo #(.DEPTH(OST_DEPTH), .WIDTH(ENT_W)) u_ost_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_fire),
    .wdata ({idx, num_eff(cmd_q.num)}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_idx = fifo_rdata[NUM_W +: IDX_W];
  assign head_num = fifo_rdata[NUM_W-1:0];
  assign b_fire   = axi_lsu_bvld && lsu_axi_brdy;
  assign b_last   = (resp_cnt + NUM_W'(1)) == head_num;
  assign fifo_pop = b_fire && !fifo_empty && b_last;
  assign acc_next = bresp_max(resp_acc, axi_lsu_bresp);

  // Response merge; brdy is low while a merged response waits, so the accumulator is idle then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt  <= '0;
      resp_acc  <= BRESP_OKAY;
      resp_hold <= 1'b0;
      bidx      <= '0;
      bresp_q   <= BRESP_OKAY;
      brdy_en   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      brdy_en <= 1'b1;
      if (resp_hold) begin
        if (req_brdy[bidx]) begin
          resp_hold <= 1'b0;
          resp_acc  <= BRESP_OKAY;
        end
      end else if (b_fire) begin
        if (fifo_empty) begin
          err_unexp <= err_unexp | 1'b1;
        end else if (b_last) begin
          resp_hold <= 1'b1;
          bidx      <= head_idx;
          bresp_q   <= acc_next;
          resp_cnt  <= '0;
        end else begin
          resp_cnt <= resp_cnt + NUM_W'(1);
          resp_acc <= acc_next;
        end
      end
    end
  end

  assign lsu_axi_brdy = brdy_en && !resp_hold;
  assign req_bvld     = resp_hold ? (NUM_REQ'(1) << bidx) : '0;
  assign req_bresp    = bresp_q;

endmodule

// File: tb/tb_lsu_axi_wr_arb.sv
// Directed bench for lsu_axi_wr_arb: single command, arbitration, error merge, FIFO full,
// response backpressure and reset in the middle of a burst.
module tb_lsu_axi_wr_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_awvld;
  logic [39:0]  req_awaddr;
  logic [31:0]  req_awlen;
  logic [11:0]  req_awsize;
  logic [7:0]   req_awburst;
  logic [11:0]  req_awstr;
  logic [15:0]  req_awnum;
  logic [47:0]  req_oram_addr;
  logic [3:0]   req_awrdy;
  logic [255:0] req_wdata;
  logic [31:0]  req_wstrb;
  logic [3:0]   req_wvld;
  logic [3:0]   req_wrdy;
  logic [3:0]   req_bvld;
  logic [1:0]   req_bresp;
  logic [3:0]   req_brdy;
  logic [7:0]   lsu_axi_awid;
  logic [9:0]   lsu_axi_awaddr;
  logic [7:0]   lsu_axi_awlen;
  logic [2:0]   lsu_axi_awsize;
  logic [1:0]   lsu_axi_awburst;
  logic [2:0]   lsu_axi_awstr;
  logic [3:0]   lsu_axi_awnum;
  logic         lsu_axi_awvld;
  logic [11:0]  lsu_axi_oram_addr;
  logic         axi_lsu_awrdy;
  logic [63:0]  lsu_axi_wdata;
  logic [7:0]   lsu_axi_wstrb;
  logic         lsu_axi_wlast;
  logic         lsu_axi_wvld;
  logic         axi_lsu_wrdy;
  logic [1:0]   axi_lsu_bresp;
  logic         axi_lsu_bvld;
  logic         lsu_axi_brdy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_axi_wr_arb dut (
    .clk(clk), .rst(rst),
    .req_awvld(req_awvld), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .req_awsize(req_awsize), .req_awburst(req_awburst), .req_awstr(req_awstr),
    .req_awnum(req_awnum), .req_oram_addr(req_oram_addr), .req_awrdy(req_awrdy),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wvld(req_wvld), .req_wrdy(req_wrdy),
    .req_bvld(req_bvld), .req_bresp(req_bresp), .req_brdy(req_brdy),
    .lsu_axi_awid(lsu_axi_awid), .lsu_axi_awaddr(lsu_axi_awaddr), .lsu_axi_awlen(lsu_axi_awlen),
    .lsu_axi_awsize(lsu_axi_awsize), .lsu_axi_awburst(lsu_axi_awburst),
    .lsu_axi_awstr(lsu_axi_awstr), .lsu_axi_awnum(lsu_axi_awnum), .lsu_axi_awvld(lsu_axi_awvld),
    .lsu_axi_oram_addr(lsu_axi_oram_addr), .axi_lsu_awrdy(axi_lsu_awrdy),
    .lsu_axi_wdata(lsu_axi_wdata), .lsu_axi_wstrb(lsu_axi_wstrb), .lsu_axi_wlast(lsu_axi_wlast),
    .lsu_axi_wvld(lsu_axi_wvld), .axi_lsu_wrdy(axi_lsu_wrdy), .axi_lsu_bresp(axi_lsu_bresp),
    .axi_lsu_bvld(axi_lsu_bvld), .lsu_axi_brdy(lsu_axi_brdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [9:0] addr, input logic [7:0] len,
                         input logic [3:0] num);
    req_awaddr[r*10 +: 10]   = addr;
    req_awlen[r*8 +: 8]      = len;
    req_awsize[r*3 +: 3]     = 3'd3;
    req_awburst[r*2 +: 2]    = 2'd1;
    req_awstr[r*3 +: 3]      = 3'(r);
    req_awnum[r*4 +: 4]      = num;
    req_oram_addr[r*12 +: 12] = 12'h100 + 12'(r);
  endtask

  task automatic drive_defaults();
    req_awvld = '0; req_awaddr = '0; req_awlen = '0; req_awsize = '0; req_awburst = '0;
    req_awstr = '0; req_awnum = '0; req_oram_addr = '0;
    for (int r = 0; r < 4; r++) begin
      req_wdata[r*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(r);
      req_wstrb[r*8 +: 8]   = 8'hFF;
    end
    req_wvld = 4'hF; req_brdy = 4'hF;
    axi_lsu_awrdy = 1'b0; axi_lsu_wrdy = 1'b1; axi_lsu_bvld = 1'b0; axi_lsu_bresp = 2'd0;
  endtask

  task automatic do_reset();
    drive_defaults();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    drive_defaults();
    rst = 1'b1;
    tick();
    tests++; if (lsu_axi_awvld !== 1'b0) begin fails++; $display("FAIL reset_awvld: got %0b exp 0", lsu_axi_awvld); end
    tests++; if (lsu_axi_wvld !== 1'b0) begin fails++; $display("FAIL reset_wvld: got %0b exp 0", lsu_axi_wvld); end
    tests++; if (lsu_axi_brdy !== 1'b0) begin fails++; $display("FAIL reset_brdy: got %0b exp 0", lsu_axi_brdy); end
    tests++; if ({req_awrdy, req_wrdy, req_bvld} !== 12'h0) begin fails++; $display("FAIL reset_req_hs: got %0h exp 0", {req_awrdy, req_wrdy, req_bvld}); end
    tests++; if (lsu_axi_awaddr !== 10'h0 || lsu_axi_awid !== 8'h0) begin fails++; $display("FAIL reset_payload: got %0h/%0h exp 0/0", lsu_axi_awaddr, lsu_axi_awid); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_cmd(0, 10'h155, 8'd3, 4'd2);
    req_awvld = 4'b0001;
    #1;
    tests++; if (lsu_axi_awvld !== 1'b0) begin fails++; $display("FAIL single_no_early_awvld: got %0b exp 0", lsu_axi_awvld); end
    tick();
    tests++; if (lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL single_awvld_latency: got %0b exp 1", lsu_axi_awvld); end
    tests++; if ({lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awnum} !== {8'd0, 10'h155, 8'd3, 4'd2}) begin
      fails++; $display("FAIL single_aw_payload: got %0h/%0h/%0h/%0h exp 0/155/3/2", lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awnum);
    end
    axi_lsu_awrdy = 1'b1;
    #1;
    tests++; if (req_awrdy !== 4'b0001) begin fails++; $display("FAIL single_awrdy_pulse: got %0b exp 0001", req_awrdy); end
    tick();
    axi_lsu_awrdy = 1'b0;
    req_awvld = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      tests++; if (lsu_axi_wvld !== 1'b1 || req_wrdy !== 4'b0001) begin fails++; $display("FAIL single_beat%0d_vld: got %0b/%0b exp 1/0001", b, lsu_axi_wvld, req_wrdy); end
      tests++; if (lsu_axi_wlast !== ((b == 3) || (b == 7))) begin fails++; $display("FAIL single_beat%0d_wlast: got %0b exp %0b", b, lsu_axi_wlast, (b == 3) || (b == 7)); end
      tick();
    end
    tests++; if (lsu_axi_wvld !== 1'b0) begin fails++; $display("FAIL single_after_8_beats: wvld got %0b exp 0", lsu_axi_wvld); end
    axi_lsu_bvld = 1'b1;
    axi_lsu_bresp = 2'd0;
    #1;
    tests++; if (lsu_axi_brdy !== 1'b1) begin fails++; $display("FAIL single_brdy: got %0b exp 1", lsu_axi_brdy); end
    tick();
    tests++; if (req_bvld !== 4'b0000) begin fails++; $display("FAIL single_no_early_bvld: got %0b exp 0000", req_bvld); end
    tick();
    axi_lsu_bvld = 1'b0;
    tests++; if (req_bvld !== 4'b0001 || req_bresp !== 2'd0) begin fails++; $display("FAIL single_merged_b: got %0b/%0d exp 0001/0", req_bvld, req_bresp); end
    tick();
    tests++; if (req_bvld !== 4'b0000) begin fails++; $display("FAIL single_b_release: got %0b exp 0000", req_bvld); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_id;
    int n;
    do_reset();
    for (int r = 0; r < 4; r++) set_cmd(r, 10'(r * 16), 8'd0, 4'd1);
    req_awvld = 4'hF;
    axi_lsu_awrdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef WR_ARB_FIXED_PRIO_EN
      exp_id = 8'd0;
`else
      exp_id = 8'(k % 4);
`endif
      n = 0;
      while (lsu_axi_awvld !== 1'b1 && n < 20) begin tick(); n++; end
      tests++; if (lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL rr_grant%0d_timeout: awvld got %0b exp 1", k, lsu_axi_awvld); end
      tests++; if (lsu_axi_awid !== exp_id) begin fails++; $display("FAIL rr_grant%0d_id: got %0d exp %0d", k, lsu_axi_awid, exp_id); end
      tick();
      tick();
      axi_lsu_bvld = 1'b1;
      tick();
      axi_lsu_bvld = 1'b0;
    end
    req_awvld = 4'h0;
    axi_lsu_awrdy = 1'b0;
  endtask

  task automatic test_err_merge();
    logic [1:0] resps [3];
    int n;
    resps = '{2'd0, 2'd2, 2'd0};
    do_reset();
    req_brdy = 4'h0;
    set_cmd(1, 10'h02A, 8'd0, 4'd3);
    req_awvld = 4'b0010;
    axi_lsu_awrdy = 1'b1;
    n = 0;
    while (lsu_axi_awvld !== 1'b1 && n < 20) begin tick(); n++; end
    tests++; if (lsu_axi_awid !== 8'd1 || lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL err_grant: id %0d vld %0b exp 1/1", lsu_axi_awid, lsu_axi_awvld); end
    tick();
    req_awvld = 4'b0000;
    axi_lsu_awrdy = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      axi_lsu_bvld = 1'b1;
      axi_lsu_bresp = resps[i];
      tick();
      if (i < 2) begin
        tests++; if (req_bvld !== 4'b0000) begin fails++; $display("FAIL err_partial%0d: req_bvld got %0b exp 0000", i, req_bvld); end
      end
    end
    axi_lsu_bvld = 1'b0;
    axi_lsu_bresp = 2'd0;
    tests++; if (req_bvld !== 4'b0010 || req_bresp !== 2'd2) begin fails++; $display("FAIL err_merged: got %0b/%0d exp 0010/2", req_bvld, req_bresp); end
    tests++; if (lsu_axi_brdy !== 1'b0) begin fails++; $display("FAIL err_hold_brdy: got %0b exp 0", lsu_axi_brdy); end
    req_brdy = 4'b0010;
    tick();
    tests++; if (req_bvld !== 4'b0000) begin fails++; $display("FAIL err_release: got %0b exp 0000", req_bvld); end
  endtask

  task automatic test_fifo_full();
    int n;
    do_reset();
    set_cmd(2, 10'h0C0, 8'd0, 4'd1);
    req_awvld = 4'b0100;
    axi_lsu_awrdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n = 0;
      while (lsu_axi_awvld !== 1'b1 && n < 20) begin tick(); n++; end
      tests++; if (lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL full_issue%0d_timeout: awvld got %0b exp 1", c, lsu_axi_awvld); end
      tick();
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      tests++; if (lsu_axi_awvld !== 1'b0) begin fails++; $display("FAIL full_no_grant%0d: awvld got %0b exp 0", c, lsu_axi_awvld); end
      tick();
    end
    axi_lsu_bvld = 1'b1;
    tick();
    axi_lsu_bvld = 1'b0;
    tests++; if (req_bvld !== 4'b0100) begin fails++; $display("FAIL full_merged: got %0b exp 0100", req_bvld); end
    tests++; if (lsu_axi_awvld !== 1'b0) begin fails++; $display("FAIL full_pop_cycle: awvld got %0b exp 0", lsu_axi_awvld); end
    tick();
    tests++; if (lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL full_grant_after_pop: awvld got %0b exp 1", lsu_axi_awvld); end
    req_awvld = 4'b0000;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    req_brdy = 4'h0;
    set_cmd(0, 10'h010, 8'd0, 4'd1);
    set_cmd(1, 10'h020, 8'd0, 4'd1);
    axi_lsu_awrdy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_awvld = 4'(1 << c);
      n = 0;
      while (lsu_axi_awvld !== 1'b1 && n < 20) begin tick(); n++; end
      tests++; if (lsu_axi_awid !== 8'(c) || lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL bp_issue%0d: id %0d vld %0b exp %0d/1", c, lsu_axi_awid, lsu_axi_awvld, c); end
      tick();
      req_awvld = 4'h0;
      tick();
    end
    axi_lsu_awrdy = 1'b0;
    axi_lsu_bvld = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      tests++; if (lsu_axi_brdy !== 1'b0 || req_bvld !== 4'b0001) begin fails++; $display("FAIL bp_hold%0d: brdy %0b bvld %0b exp 0/0001", c, lsu_axi_brdy, req_bvld); end
      tick();
    end
    req_brdy = 4'b0001;
    #1;
    tests++; if (lsu_axi_brdy !== 1'b0) begin fails++; $display("FAIL bp_brdy_same_cycle: got %0b exp 0", lsu_axi_brdy); end
    tick();
    tests++; if (lsu_axi_brdy !== 1'b1 || req_bvld !== 4'b0000) begin fails++; $display("FAIL bp_resume: brdy %0b bvld %0b exp 1/0000", lsu_axi_brdy, req_bvld); end
    tick();
    axi_lsu_bvld = 1'b0;
    tests++; if (req_bvld !== 4'b0010) begin fails++; $display("FAIL bp_second_b: got %0b exp 0010", req_bvld); end
  endtask

  task automatic test_reset_mid_data();
    int n;
    do_reset();
    set_cmd(3, 10'h3FF, 8'd7, 4'd1);
    req_awvld = 4'b1000;
    axi_lsu_awrdy = 1'b1;
    n = 0;
    while (lsu_axi_awvld !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    req_awvld = 4'h0;
    axi_lsu_awrdy = 1'b0;
    tick();
    tick();
    tests++; if (lsu_axi_wvld !== 1'b1 || req_wrdy !== 4'b1000) begin fails++; $display("FAIL rst_pre_in_data: wvld %0b wrdy %0b exp 1/1000", lsu_axi_wvld, req_wrdy); end
    rst = 1'b1;
    #1;
    tests++; if ({lsu_axi_wvld, lsu_axi_awvld, lsu_axi_wlast} !== 3'b000 || req_wrdy !== 4'h0) begin
      fails++; $display("FAIL rst_valids_cleared: wvld/awvld/wlast %0b wrdy %0b exp 000/0000", {lsu_axi_wvld, lsu_axi_awvld, lsu_axi_wlast}, req_wrdy);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (lsu_axi_awaddr !== 10'h0) begin fails++; $display("FAIL rst_payload: awaddr got %0h exp 0", lsu_axi_awaddr); end
    axi_lsu_bvld = 1'b1;
    tick();
    axi_lsu_bvld = 1'b0;
    tests++; if (req_bvld !== 4'h0) begin fails++; $display("FAIL rst_fifo_empty: stray B gave req_bvld %0b exp 0000", req_bvld); end
    set_cmd(0, 10'h001, 8'd0, 4'd1);
    req_awvld = 4'b0001;
    tick();
    tests++; if (lsu_axi_awvld !== 1'b1) begin fails++; $display("FAIL rst_fsm_idle: awvld got %0b exp 1", lsu_axi_awvld); end
    req_awvld = 4'h0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_err_merge();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
